dest_drain_counter: RTL
=======================

Name: dest_drain_counter

Overview:
- Downstream stage of the transmission-layer logic.
- Drains the two destination FIFOs (D0, D1) by driving their pop inputs, merges the popped words into one registered output stream, and keeps per-destination word counters.
- The counters are read out through a request/index handshake.
- Sits between the final demux/FIFO stage and the link-side consumer or checker.

Parameters:
- data_width, 6, width of each FIFO word.
- count_width, 5, width of each per-destination counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_L  input  1  synchronous active-low reset. Sampled on rising edge of clk; while low, all state clears on the next edge.
- enable  input  1  permits draining when high.
- empty_D0  input  1  D0 FIFO empty flag.
- empty_D1  input  1  D1 FIFO empty flag.
- data_D0  input  data_width  D0 FIFO head word; show-ahead, valid in the same cycle as the pop.
- data_D1  input  data_width  D1 FIFO head word; show-ahead.
- D0_pop  output  1  pop strobe to D0 FIFO.
- D1_pop  output  1  pop strobe to D1 FIFO.
- data_out  output  data_width  registered merged word.
- dest_out  output  1  source of data_out (0=D0, 1=D1).
- valid_out  output  1  data_out/dest_out valid.
- req  input  1  counter readout request.
- idx  input  1  counter select (0=D0, 1=D1).
- count_out  output  count_width  returned counter value.
- count_valid  output  1  count_out valid.
- state_out  output  2  current FSM state encoding.

Behaviour:
- Reset values while reset_L low at an edge:
  - FSM = RESET.
  - Counters = 0; round-robin pointer = D0.
  - data_out=0, dest_out=0, valid_out=0, count_out=0, count_valid=0.
  - D0_pop and D1_pop are forced 0 combinationally whenever reset_L=0.
- FSM states and encoding: RESET=0, IDLE=1, ACTIVE=2.
  - RESET -> IDLE on the first edge with reset_L=1.
  - IDLE -> ACTIVE when enable=1 and (!empty_D0 or !empty_D1).
  - ACTIVE -> IDLE when enable=0 or both FIFOs empty.
  - Any state -> RESET when reset_L=0.
- Pop rule (combinational, asserted only in ACTIVE with enable=1):
  - At most one pop per cycle; pops are one-hot or zero.
  - Only one FIFO non-empty: pop that FIFO.
  - Both non-empty: pop the FIFO selected by the round-robin pointer; the pointer toggles after each contested grant.
  - Uncontested grants do not move the pointer.
  - Never pop a FIFO whose empty flag is 1 in that cycle.
- Data path latency is 1 cycle:
  - A pop in cycle N gives data_out = popped word, dest_out = source, valid_out=1 at N+1.
  - valid_out=0 in any cycle following a no-pop cycle.
  - data_out holds its last value when not valid.
- Counters:
  - cnt_D0 and cnt_D1 each increment by 1 on every pop of their FIFO, in the same edge as the data capture.
  - Default arithmetic is modulo 2^count_width; 31 -> 0 wraps.
- Readout handshake:
  - req is honoured only when the FSM is in IDLE.
  - In that case count_out = cnt[idx] and count_valid=1 on the next cycle, for exactly one cycle per cycle that req is high.
  - req in RESET or ACTIVE is ignored: count_valid=0.
  - Counters are never cleared except by reset.
- Mid-operation reset: a pop in progress is discarded, valid_out is 0 at the following edge, and the pointer returns to D0.
- enable falling in ACTIVE: no pop in that cycle; FSM moves to IDLE at the next edge; a word popped in the prior cycle still appears on data_out.

Optional Feature:
- Macro: COUNT_SATURATE_EN.
- Defined: each counter saturates at 2^count_width-1 (31) and holds there on further pops.
- Undefined: counters wrap to 0.
- Data path is unaffected either way.

Decomposition:
- Shared package holds:
  - state encodings ST_RESET, ST_IDLE, ST_ACTIVE;
  - DEST_D0/DEST_D1 constants;
  - default widths (data_width=6, count_width=5).
- One natural sub-module, rr_arbiter_2: two request inputs, one-hot grant, registered pointer, synchronous active-low reset.

Test Plan:
- Reset then enable=1; D0 holds 0x11,0x12, D1 empty -> D0_pop high 2 cycles; data_out 0x11 then 0x12, dest_out=0, valid_out 1 cycle after each pop; cnt_D0=2.
- Both FIFOs non-empty (D0: 0x01,0x02; D1: 0x21,0x22) -> pop order D0,D1,D0,D1; data_out 0x01,0x21,0x02,0x22; never both pops high.
- Drain to IDLE; req=1, idx=1 for one cycle -> next cycle count_valid=1, count_out=2; req during ACTIVE -> count_valid stays 0.
- 33 pops from D0:
  - without COUNT_SATURATE_EN, cnt_D0 reads 1;
  - with COUNT_SATURATE_EN, cnt_D0 reads 31.
- reset_L=0 for one cycle mid-drain -> pops 0 immediately; at the next edge all outputs 0, state_out=0, counters 0; after release, first contested grant goes to D0.
- enable=0 with both FIFOs non-empty -> no pops, state_out=1 (IDLE), valid_out=0.

Source files
------------

// File: rtl/dest_drain_counter_pkg.sv
// Shared types and defaults for the destination drain counter.
// Optional saturation is selected by COUNT_SATURATE_EN in the top module.
package dest_drain_counter_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    localparam logic DEST_D0 = 1'b0;
    localparam logic DEST_D1 = 1'b1;

    localparam int unsigned DATA_WIDTH  = 6;
    localparam int unsigned COUNT_WIDTH = 5;

endpackage

// File: rtl/dest_drain_counter_rr_arbiter_2.sv
// Two-way round-robin arbiter with one-hot grant.
// The pointer only moves when both requesters compete.
module rr_arbiter_2
    import dest_drain_counter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_L,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        grant = req;
        if (req == 2'b11) begin
            grant = (ptr_q == DEST_D1) ? 2'b10 : 2'b01;
            ptr_d = ~ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            ptr_q <= DEST_D0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dest_drain_counter.sv
// Drains FIFOs D0/D1 into one registered stream and counts words per destination.
// Define COUNT_SATURATE_EN to make the counters saturate instead of wrap.
module dest_drain_counter
    import dest_drain_counter_pkg::*;
#(
    parameter int unsigned data_width  = DATA_WIDTH,
    parameter int unsigned count_width = COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic                   enable,
    input  logic                   empty_D0,
    input  logic                   empty_D1,
    input  logic [data_width-1:0]  data_D0,
    input  logic [data_width-1:0]  data_D1,
    output logic                   D0_pop,
    output logic                   D1_pop,
    output logic [data_width-1:0]  data_out,
    output logic                   dest_out,
    output logic                   valid_out,
    input  logic                   req,
    input  logic                   idx,
    output logic [count_width-1:0] count_out,
    output logic                   count_valid,
    output logic [1:0]             state_out
);

    state_e state_q, state_d;

    logic                   pop_allow;
    logic [1:0]             arb_req;
    logic [1:0]             grant;
    logic                   any_pop;

    logic [data_width-1:0]  data_q, data_d;
    logic                   dest_q, dest_d;
    logic                   valid_q, valid_d;
    logic [count_width-1:0] cnt_q [2];
    logic [count_width-1:0] cnt_d [2];
    logic [count_width-1:0] count_q, count_d;
    logic                   count_valid_q, count_valid_d;

    function automatic logic [count_width-1:0] cnt_inc(input logic [count_width-1:0] c);
`ifdef COUNT_SATURATE_EN
        return (&c) ? c : c + count_width'(1);
`else
        return c + count_width'(1);
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET:  state_d = ST_IDLE;
            ST_IDLE:   if (enable && (!empty_D0 || !empty_D1)) state_d = ST_ACTIVE;
            ST_ACTIVE: if (!enable || (empty_D0 && empty_D1)) state_d = ST_IDLE;
            default:   state_d = ST_RESET;
        endcase
    end

    // reset_L in the gate keeps pops low combinationally during reset
    assign pop_allow = reset_L && enable && (state_q == ST_ACTIVE);
    assign arb_req   = {pop_allow & ~empty_D1, pop_allow & ~empty_D0};

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .reset_L (reset_L),
        .req     (arb_req),
        .grant   (grant)
    );

    assign D0_pop  = grant[0];
    assign D1_pop  = grant[1];
    assign any_pop = |grant;

    always_comb begin
        data_d        = data_q;
        dest_d        = dest_q;
        valid_d       = 1'b0;
        cnt_d[0]      = cnt_q[0];
        cnt_d[1]      = cnt_q[1];
        count_valid_d = (state_q == ST_IDLE) && req;
        count_d       = count_q;
        if (any_pop) begin
            data_d  = D1_pop ? data_D1 : data_D0;
            dest_d  = D1_pop ? DEST_D1 : DEST_D0;
            valid_d = 1'b1;
        end
        if (D0_pop) cnt_d[0] = cnt_inc(cnt_q[0]);
        if (D1_pop) cnt_d[1] = cnt_inc(cnt_q[1]);
        if (count_valid_d) count_d = cnt_q[idx];
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q       <= ST_RESET;
            data_q        <= '0;
            dest_q        <= DEST_D0;
            valid_q       <= 1'b0;
            cnt_q         <= '{default: '0};
            count_q       <= '0;
            count_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            dest_q        <= dest_d;
            valid_q       <= valid_d;
            cnt_q         <= cnt_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
        end
    end

    assign data_out    = data_q;
    assign dest_out    = dest_q;
    assign valid_out   = valid_q;
    assign count_out   = count_q;
    assign count_valid = count_valid_q;
    assign state_out   = state_q;

endmodule
